// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default oversampling and the
// 8N1 frame constants. The transmitter uses the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int unsigned UART_OVS_DEFAULT = 16;
  localparam int unsigned UART_DATA_BITS   = 8;
  localparam logic        UART_START_LEVEL = 1'b0;
  localparam logic        UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Generic single-bit synchronizer; the chain resets to 1 so that an idle-high
// serial line does not look like a start bit when reset is released.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_q <= '1;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVS-times oversampling and framing-error detection.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | line idle, waiting for a low sample on an rxen tick
//   ST_START     | counting to the middle of the start bit to reject glitches
//   ST_DATA      | sampling 8 data bits, LSB first, at each bit's tick OVS-1
//   ST_STOP      | sampling the stop bit; 1 -> rx_valid, 0 -> frame_err
//   ST_WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS         = UART_OVS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxen,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int DW = UART_DATA_BITS;
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVS - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DW - 1);

  logic          rxd_s;
  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (rxd),
    .q     (rxd_s)
  );

  // State, counters, shift register and output pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; nothing advances without rxen, and the pulse outputs
  // default low so each lasts one clk whatever the rxen pattern.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (rxen) begin
      case (state_q)
        ST_IDLE: begin
          if (rxd_s == UART_START_LEVEL) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end

        ST_START: begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rxd_s == UART_START_LEVEL) begin
              state_d = ST_DATA;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_DATA: begin
          if (tick_q == TICK_END) begin
            shift_d = {rxd_s, shift_q[DW-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_STOP: begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            if (rxd_s == UART_STOP_LEVEL) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_WAIT_IDLE: begin
          if (rxd_s == UART_STOP_LEVEL) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// checked against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int OVS = 16;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxen  = 1'b1;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rxen      (rxen),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int div    = 1;
  int ph     = 0;
  int fall_cyc = 0;
  logic [7:0] last_good = 8'h00;

  // Observed events and the model's expected events.
  bit         ev_err[$];
  logic [7:0] ev_data[$];
  int         ev_cyc[$];
  bit         exp_err[$];
  logic [7:0] exp_data[$];

  int viol_excl = 0, viol_width = 0, viol_stab = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // rxen: one pulse every div clks (held high when div == 1).
  initial forever begin
    @(posedge clk);
    #1;
    ph   = (ph + 1 >= div) ? 0 : ph + 1;
    rxen = (ph == 0);
  end

  // Monitor: record pulses and count protocol violations.
  initial begin
    logic       prev_v, prev_e;
    logic [7:0] prev_data;
    prev_v = 1'b0; prev_e = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_valid && frame_err) viol_excl++;
      if ((rx_valid && prev_v) || (frame_err && prev_e)) viol_width++;
      if (!rx_valid && n_rst && rx_data !== prev_data) viol_stab++;
      if (rx_valid)  begin ev_err.push_back(1'b0); ev_data.push_back(rx_data); ev_cyc.push_back(cyc); end
      if (frame_err) begin ev_err.push_back(1'b1); ev_data.push_back(rx_data); ev_cyc.push_back(cyc); end
      prev_v = rx_valid; prev_e = frame_err; prev_data = rx_data;
    end
  end

  task automatic hold_line(input logic v, input int bits);
    rxd = v;
    repeat (bits * OVS * div) @(posedge clk);
    #1;
  endtask

  // Drive one frame and push the model's expected outcome: a good stop bit
  // yields the byte, a low stop bit yields frame_err with rx_data unchanged.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int extra_low);
    fall_cyc = cyc;
    hold_line(1'b0, 1);
    for (int i = 0; i < 8; i++) hold_line(d[i], 1);
    hold_line(stop_lvl, stop_lvl ? 1 : 1 + extra_low);
    exp_err.push_back(!stop_lvl);
    exp_data.push_back(stop_lvl ? d : last_good);
    if (stop_lvl) last_good = d;
  endtask

  task automatic flush(input string tag, output int last_cyc);
    int n;
    n = 0;
    last_cyc = -1;
    while (ev_err.size() < exp_err.size() && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    while (exp_err.size() > 0) begin
      if (ev_err.size() == 0) begin
        check({tag, "_missing"}, 32'd0, 32'd1);
        void'(exp_err.pop_front());
        void'(exp_data.pop_front());
      end else begin
        last_cyc = ev_cyc.pop_front();
        check({tag, "_kind"}, 32'(ev_err.pop_front()), 32'(exp_err.pop_front()));
        check({tag, "_data"}, 32'(ev_data.pop_front()), 32'(exp_data.pop_front()));
      end
    end
    check({tag, "_extra"}, ev_err.size(), 0);
    ev_err.delete(); ev_data.delete(); ev_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int lc, lat;
    logic [7:0] d;
    logic bad;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(rx_data),   32'h00);
    check("rst_valid", 32'(rx_valid),  32'h0);
    check("rst_err",   32'(frame_err), 32'h0);
    check("rst_busy",  32'(rx_busy),   32'h0);
    n_rst = 1'b1;
    hold_line(1'b1, 1);

    // Basic frame and latency.
    send_frame(8'hA5, 1'b1, 0);
    flush("a5", lc);
    check("lat_a5", 32'(lc - fall_cyc), 32'd155);
    check("data_a5", 32'(rx_data), 32'hA5);
    hold_line(1'b1, 1);

    // Short glitch on the line.
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    check("glitch_busy_hi", 32'(rx_busy), 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check("glitch_busy_lo", 32'(rx_busy), 32'd0);
    flush("glitch", lc);
    send_frame(8'h3C, 1'b1, 0);
    flush("3c", lc);
    check("data_3c", 32'(rx_data), 32'h3C);
    hold_line(1'b1, 1);

    // Framing error with a held break.
    send_frame(8'h96, 1'b0, 2);
    check("ferr_busy_hi", 32'(rx_busy), 32'd1);
    flush("ferr", lc);
    check("ferr_hold", 32'(rx_data), 32'h3C);
    hold_line(1'b1, 1);
    check("ferr_busy_lo", 32'(rx_busy), 32'd0);

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    flush("b2b", lc);
    check("data_ff", 32'(rx_data), 32'hFF);
    hold_line(1'b1, 1);

    // Sparse rxen: one tick every 4 clks.
    div = 4;
    hold_line(1'b1, 1);
    send_frame(8'h5A, 1'b1, 0);
    flush("div4", lc);
    lat = lc - fall_cyc;
    check("lat_div4", 32'(lat >= 611 && lat <= 614), 32'd1);
    check("data_5a", 32'(rx_data), 32'h5A);
    div = 1;
    hold_line(1'b1, 1);

    // Reset during bit 4.
    d = 8'hC3;
    hold_line(1'b0, 1);
    for (int i = 0; i < 4; i++) hold_line(d[i], 1);
    rxd = d[4];
    repeat (8) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("mrst_data",  32'(rx_data),   32'h00);
    check("mrst_valid", 32'(rx_valid),  32'h0);
    check("mrst_err",   32'(frame_err), 32'h0);
    check("mrst_busy",  32'(rx_busy),   32'h0);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_rst = 1'b1;
    last_good = 8'h00;
    hold_line(1'b1, 1);
    flush("mrst", lc);
    send_frame(8'hC3, 1'b1, 0);
    flush("c3", lc);
    check("data_c3", 32'(rx_data), 32'hC3);
    hold_line(1'b1, 1);

    // Constant low line: exactly one framing error, then parked.
    hold_line(1'b0, 12);
    exp_err.push_back(1'b1);
    exp_data.push_back(last_good);
    check("brk_busy", 32'(rx_busy), 32'd1);
    flush("brk", lc);
    hold_line(1'b1, 1);
    check("brk_busy_lo", 32'(rx_busy), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 20; k++) begin
      div = int'($urandom_range(1, 3));
      hold_line(1'b1, 1);
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad, bad ? int'($urandom_range(0, 2)) : 0);
      if (bad) hold_line(1'b1, 1);
      flush("rnd", lc);
      check("rnd_data", 32'(rx_data), 32'(last_good));
    end

    check("excl_viol",  viol_excl,  0);
    check("width_viol", viol_width, 0);
    check("stab_viol",  viol_stab,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
